// File: rtl/execute_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider for the execute stage (MUL, UMULH, SMULH, UDIV, SDIV).
// Optional macro MULDIV_EARLY_OUT_EN: skip iteration for zero operands and illegal ops.
`ifndef WORD
`define WORD 64
`endif

module execute_muldiv_unit #(
  parameter int WORD  = `WORD,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [WORD-1:0] operand_a,
  input  logic [WORD-1:0] operand_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [WORD-1:0] result
);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULH = 3'b001;
  localparam logic [2:0] OP_SMULH = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b011;
  localparam logic [2:0] OP_SDIV  = 3'b100;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD-1:0]  acc_q, acc_d;
  logic [WORD-1:0]  lo_q, lo_d;
  logic [WORD-1:0]  opnd_q, opnd_d;
  logic             signNeg_q, signNeg_d;
  logic             bZero_q, bZero_d;
  logic             done_q, done_d;
  logic [WORD-1:0]  result_q, result_d;

  logic            signedIn, divIn, earlyOut;
  logic [WORD-1:0] aMag, bMag;
  logic            divOp;
  logic [WORD:0]   mulSum, mulHi;
  logic [WORD:0]   trialRem;
  logic            noBorrow;
  logic [WORD-1:0] remSub;

  assign signedIn = (op == OP_SMULH) || (op == OP_SDIV);
  assign divIn    = (op == OP_UDIV) || (op == OP_SDIV);
  assign aMag     = (signedIn && operand_a[WORD-1]) ? -operand_a : operand_a;
  assign bMag     = (signedIn && operand_b[WORD-1]) ? -operand_b : operand_b;

`ifdef MULDIV_EARLY_OUT_EN
  assign earlyOut = (operand_b == '0) || ((operand_a == '0) && !divIn && (op <= OP_SMULH)) ||
                    (op > OP_SDIV);
`else
  assign earlyOut = 1'b0;
`endif

  // One radix-2 step of each datapath; CALC picks whichever the latched op needs.
  assign divOp    = (op_q == OP_UDIV) || (op_q == OP_SDIV);
  assign mulSum   = {1'b0, acc_q} + {1'b0, opnd_q};
  assign mulHi    = lo_q[0] ? mulSum : {1'b0, acc_q};
  // The trial remainder keeps WORD+1 bits so divisors with the MSB set still divide correctly.
  assign trialRem = {acc_q, lo_q[WORD-1]};
  assign noBorrow = trialRem >= {1'b0, opnd_q};
  assign remSub   = trialRem[WORD-1:0] - opnd_q;

  // Next-state, datapath and result logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    signNeg_d = signNeg_q;
    bZero_d   = bZero_q;
    done_d    = 1'b0;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          signNeg_d = signedIn && (operand_a[WORD-1] ^ operand_b[WORD-1]);
          bZero_d   = (operand_b == '0);
          cnt_d     = '0;
          acc_d     = '0;
          lo_d      = divIn ? aMag : bMag;
          opnd_d    = divIn ? bMag : aMag;
          if (earlyOut) begin
            lo_d    = '0;
            state_d = FINISH;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (divOp) begin
          acc_d = noBorrow ? remSub : trialRem[WORD-1:0];
          lo_d  = {lo_q[WORD-2:0], noBorrow};
        end else begin
          acc_d = mulHi[WORD:1];
          lo_d  = {mulHi[0], lo_q[WORD-1:1]};
        end
        if (cnt_q == CNT_W'(WORD-1)) state_d = FINISH;
      end
      FINISH: begin
        // SMULH high half of the negated product: ~hi plus the carry out of ~lo + 1.
        unique case (op_q)
          OP_MUL:   result_d = lo_q;
          OP_UMULH: result_d = acc_q;
          OP_SMULH: result_d = signNeg_q ? (~acc_q + WORD'(lo_q == '0)) : acc_q;
          OP_UDIV:  result_d = bZero_q ? '0 : lo_q;
          OP_SDIV:  result_d = bZero_q ? '0 : (signNeg_q ? -lo_q : lo_q);
          default:  result_d = '0;
        endcase
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      signNeg_q <= 1'b0;
      bZero_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      signNeg_q <= signNeg_d;
      bZero_q   <= bZero_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = busy | (start & ~busy);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed self-checking bench for execute_muldiv_unit at WORD=64.
// Expected early-out latencies follow MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_execute_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [63:0] operand_a;
   logic [63:0] operand_b;
   logic        busy;
   logic        stall;
   logic        done;
   logic [63:0] result;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_UMULH = 3'b001;
   localparam logic [2:0] OP_SMULH = 3'b010;
   localparam logic [2:0] OP_UDIV  = 3'b011;
   localparam logic [2:0] OP_SDIV  = 3'b100;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 65;
`endif

   execute_muldiv_unit #(.WORD(64), .CNT_W(7)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .operand_a(operand_a),
      .operand_b(operand_b),
      .busy(busy),
      .stall(stall),
      .done(done),
      .result(result)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   // Called #1 after a rising edge; the next edge (E0) accepts the request, then operands are scrambled.
   task automatic applyStimulus(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
      op        = o;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      operand_a = ~a;
      operand_b = ~b;
      op        = 3'b110;
   endtask

   // Counts edges until done is seen; -1 when the budget runs out.
   task automatic waitDone(output int edges);
      edges = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic runOp(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] expRes, input int expLat);
      int edges;
      applyStimulus(o, a, b);
      waitDone(edges);
      checkOutput({tag, "_lat"}, 64'(edges), 64'(expLat));
      checkOutput({tag, "_res"}, result, expRes);
      checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int edges;
      int strayDone;
      reset     = 1'b1;
      start     = 1'b0;
      op        = 3'b000;
      operand_a = '0;
      operand_b = '0;
      #12;
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_done", {63'd0, done}, 64'd0);
      checkOutput("rst_result", result, 64'd0);
      checkOutput("rst_stall", {63'd0, stall}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // MUL with one-cycle done pulse and result hold.
      runOp("mul", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      @(posedge clk);
      #1;
      checkOutput("mul_done_pulse", {63'd0, done}, 64'd0);
      checkOutput("mul_hold", result, 64'hFFFF_FFFF_FFFF_FFEB);

      runOp("smulh", OP_SMULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      runOp("umulh", OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000, 64'h3FFF_FFFF_FFFF_FFFF, 65);
      runOp("sdiv_neg", OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      runOp("udiv", OP_UDIV, 64'd100, 64'd7, 64'd14, 65);
      runOp("sdiv_min", OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65);
      runOp("udiv_big", OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65);
      runOp("udiv_zero", OP_UDIV, 64'd5, 64'd0, 64'd0, ZERO_LAT);
      runOp("mul_fill", OP_MUL, 64'd3, 64'd5, 64'd15, 65);
      runOp("illegal", 3'b111, 64'd9, 64'd9, 64'd0, ZERO_LAT);

      // Reset mid-calculation at counter 30 after a nonzero result is held.
      runOp("pre_rst", OP_UDIV, 64'd100, 64'd7, 64'd14, 65);
      applyStimulus(OP_MUL, 64'd11, 64'd13);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("mid_busy", {63'd0, busy}, 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("mrst_busy", {63'd0, busy}, 64'd0);
      checkOutput("mrst_done", {63'd0, done}, 64'd0);
      checkOutput("mrst_result", result, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      strayDone = 0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk);
         #1;
         if (done) strayDone++;
      end
      checkOutput("no_stray_done", 64'(strayDone), 64'd0);
      runOp("post_rst", OP_SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);

      // Start while busy is ignored; a request in the done cycle is accepted.
      applyStimulus(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      repeat (5) @(posedge clk);
      #1;
      op        = OP_UDIV;
      operand_a = 64'd100;
      operand_b = 64'd7;
      start     = 1'b1;
      #1;
      checkOutput("busy_stall", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(edges);
      checkOutput("ignore_lat", 64'(edges), 64'd59);
      checkOutput("ignore_res", result, 64'hFFFF_FFFF_FFFF_FFEB);
      checkOutput("done_cycle_busy", {63'd0, busy}, 64'd0);
      op        = OP_UDIV;
      operand_a = 64'd100;
      operand_b = 64'd7;
      start     = 1'b1;
      #1;
      checkOutput("done_cycle_stall", {63'd0, stall}, 64'd1);
      @(posedge clk);
      #1;
      start     = 1'b0;
      operand_a = 64'd1;
      checkOutput("b2b_busy", {63'd0, busy}, 64'd1);
      checkOutput("b2b_hold", result, 64'hFFFF_FFFF_FFFF_FFEB);
      waitDone(edges);
      checkOutput("b2b_lat", 64'(edges), 64'd65);
      checkOutput("b2b_res", result, 64'd14);
      @(posedge clk);
      #1;
      checkOutput("idle_stall", {63'd0, stall}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
